// File: rtl/uart_receiver_if.sv
// Receive-side handshake bundle between uart_receiver and its consumer.
// master = receiver (drives data/status, takes ack); slave = consumer.
interface uart_receiver_if;
  logic [7:0] rx_data_p;
  logic       rx_valid_p;
  logic       rx_ack_p;
  logic       frame_error_p;
  logic       overrun_p;

  modport master (
    output rx_data_p,
    output rx_valid_p,
    output frame_error_p,
    output overrun_p,
    input  rx_ack_p
  );

  modport slave (
    input  rx_data_p,
    input  rx_valid_p,
    input  frame_error_p,
    input  overrun_p,
    output rx_ack_p
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: oversampled mid-cell sampling, valid/ack delivery,
// framing-error and overrun pulses.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic            clk210_p,
  input  logic            reset_n_p,
  input  logic            baud_os_p,
  input  logic            rx_p,
  uart_receiver_if.master rx_bus
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rx_meta;
  logic              rx_s;
  logic [1:0]        settle_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;

  logic              tick_en_c;
  logic              tick_clr_c;
  logic              shift_c;
  logic              deliver_c;
  logic              frame_err_c;
  logic              first_sample_c;

  // Two-stage synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_p;
      rx_s    <= rx_meta;
    end
  end

  // rx_s first reflects the real line two clks after reset release.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      settle_cnt <= 2'd0;
    end else if (settle_cnt != 2'd3) begin
      settle_cnt <= settle_cnt + 2'd1;
    end
  end

  assign first_sample_c = (settle_cnt == 2'd2);

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_clr_c  = 1'b0;
    shift_c     = 1'b0;
    deliver_c   = 1'b0;
    frame_err_c = 1'b0;
    tick_en_c   = baud_os_p && ((state == START) || (state == DATA) || (state == STOP));
    case (state)
      IDLE: begin
        // A line already low right after reset is a break, not a start bit.
        if (!rx_s) begin
          tick_clr_c = 1'b1;
          state_nxt  = first_sample_c ? BRK_WAIT : START;
        end
      end
      START: begin
        if (baud_os_p && (tick_cnt == MID)) begin
          if (!rx_s) begin
            tick_clr_c = 1'b1;
            state_nxt  = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_os_p && (tick_cnt == LAST)) begin
          shift_c = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (baud_os_p && (tick_cnt == LAST)) begin
          if (rx_s) begin
            deliver_c = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_nxt   = BRK_WAIT;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-timing counters and shift register.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      if (tick_clr_c) begin
        tick_cnt <= '0;
      end else if (tick_en_c) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
      if (tick_clr_c) begin
        bit_cnt <= 3'd0;
      end else if (shift_c) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_c) begin
        shift_q <= {rx_s, shift_q[7:1]};
      end
    end
  end

  // Delivery beats a same-cycle ack: the fresh byte stays valid.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      rx_bus.rx_data_p     <= 8'h00;
      rx_bus.rx_valid_p    <= 1'b0;
      rx_bus.frame_error_p <= 1'b0;
      rx_bus.overrun_p     <= 1'b0;
    end else begin
      rx_bus.frame_error_p <= frame_err_c;
      rx_bus.overrun_p     <= deliver_c && rx_bus.rx_valid_p && !rx_bus.rx_ack_p;
      if (deliver_c) begin
        rx_bus.rx_data_p  <= shift_q;
        rx_bus.rx_valid_p <= 1'b1;
      end else if (rx_bus.rx_ack_p) begin
        rx_bus.rx_valid_p <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame timing, glitch, framing error,
// overrun, ack collision, baud skew and mid-frame reset.
module tb_uart_receiver;

  localparam int BIT_CLKS = 128;  // 16 ticks x 8 clks per tick

  logic clk210_p   = 1'b0;
  logic reset_n_p  = 1'b0;
  logic baud_os_p  = 1'b0;
  logic rx_p       = 1'b1;
  logic ack_manual = 1'b0;
  logic ack_auto   = 1'b0;

  uart_receiver_if bus ();
  assign bus.rx_ack_p = ack_manual | ack_auto;

  uart_receiver #(.OVERSAMPLE(16)) dut (
    .clk210_p  (clk210_p),
    .reset_n_p (reset_n_p),
    .baud_os_p (baud_os_p),
    .rx_p      (rx_p),
    .rx_bus    (bus)
  );

  always #5 clk210_p = ~clk210_p;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0, ticks = 0, e0 = -100, ticks_at_arm = 0, last_tick_edge = -1;
  int frame_id = 0, seen_id = 0, div_cnt = 0;
  int rise_cnt = 0, rise_ticks = 0, fe_cnt = 0, ov_cnt = 0, ack_fires = 0;
  logic rise_on_tick = 1'b0;
  logic valid_prev   = 1'b0;
  logic collide      = 1'b0;

  // Edge bookkeeping: E0 is the first edge seeing the start bit low.
  always @(posedge clk210_p) begin
    cyc++;
    if (baud_os_p) begin
      ticks++;
      last_tick_edge = cyc;
    end
    if (frame_id != seen_id) begin
      seen_id = frame_id;
      e0 = cyc;
    end
    if (cyc == e0 + 2) ticks_at_arm = ticks;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk210_p) begin
    if (bus.rx_valid_p && !valid_prev) begin
      rise_cnt++;
      rise_ticks   = ticks - ticks_at_arm;
      rise_on_tick = (last_tick_edge == cyc);
    end
    valid_prev = bus.rx_valid_p;
    if (bus.frame_error_p) fe_cnt++;
    if (bus.overrun_p) ov_cnt++;
  end

  // Baud tick every 8 clks; optional ack aimed at the 152nd counted tick.
  always @(negedge clk210_p) begin
    div_cnt   = (div_cnt == 7) ? 0 : div_cnt + 1;
    baud_os_p = (div_cnt == 7);
    ack_auto  = collide && baud_os_p && (cyc > e0 + 2) && (ticks - ticks_at_arm == 151);
    if (ack_auto) ack_fires++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start, data and stop; leaves the line at the stop level.
  task automatic send(input logic [7:0] d, input logic stop_bit, input int bit_clks);
    frame_id++;
    rx_p = 1'b0;
    repeat (bit_clks) @(negedge clk210_p);
    for (int i = 0; i < 8; i++) begin
      rx_p = d[i];
      repeat (bit_clks) @(negedge clk210_p);
    end
    rx_p = stop_bit;
    repeat (bit_clks) @(negedge clk210_p);
  endtask

  task automatic do_ack(input string tag);
    ack_manual = 1'b1;
    @(negedge clk210_p);
    ack_manual = 1'b0;
    check(tag, 32'(bus.rx_valid_p), 32'd0);
  endtask

  logic [7:0] lb [3] = '{8'h00, 8'hFF, 8'h5A};
  int skew [2] = '{132, 124};
  int r0, f0, o0;

  initial begin
    repeat (3) @(negedge clk210_p);
    check("rst_data",  32'(bus.rx_data_p), 32'h00);
    check("rst_valid", 32'(bus.rx_valid_p), 32'd0);
    check("rst_ferr",  32'(bus.frame_error_p), 32'd0);
    check("rst_ovr",   32'(bus.overrun_p), 32'd0);
    reset_n_p = 1'b1;
    repeat (20) @(negedge clk210_p);

    // Single frame, exact delivery timing
    send(8'hA5, 1'b1, BIT_CLKS);
    rx_p = 1'b1;
    repeat (20) @(negedge clk210_p);
    check("a5_data",     32'(bus.rx_data_p), 32'hA5);
    check("a5_valid",    32'(bus.rx_valid_p), 32'd1);
    check("a5_rises",    32'(rise_cnt), 32'd1);
    check("a5_tickcnt",  32'(rise_ticks), 32'd152);
    check("a5_on_tick",  32'(rise_on_tick), 32'd1);
    check("a5_no_err",   32'(fe_cnt + ov_cnt), 32'd0);
    do_ack("a5_ack");
    ack_manual = 1'b1;  // ack with nothing valid is ignored
    @(negedge clk210_p);
    ack_manual = 1'b0;
    check("idle_ack", 32'(bus.rx_valid_p), 32'd0);

    // Glitch: low for 5 ticks only
    r0 = rise_cnt;
    rx_p = 1'b0;
    repeat (40) @(negedge clk210_p);
    rx_p = 1'b1;
    repeat (240) @(negedge clk210_p);
    check("glitch_rise",  32'(rise_cnt), 32'(r0));
    check("glitch_valid", 32'(bus.rx_valid_p), 32'd0);
    check("glitch_err",   32'(fe_cnt + ov_cnt), 32'd0);
    send(8'h3C, 1'b1, BIT_CLKS);
    rx_p = 1'b1;
    repeat (20) @(negedge clk210_p);
    check("3c_data",  32'(bus.rx_data_p), 32'h3C);
    check("3c_valid", 32'(bus.rx_valid_p), 32'd1);
    do_ack("3c_ack");

    // Framing error with line held low
    r0 = rise_cnt;
    f0 = fe_cnt;
    send(8'h81, 1'b0, BIT_CLKS);
    repeat (320) @(negedge clk210_p);
    check("fe_pulse", 32'(fe_cnt), 32'(f0 + 1));
    check("fe_valid", 32'(bus.rx_valid_p), 32'd0);
    rx_p = 1'b1;
    repeat (1200) @(negedge clk210_p);
    check("brk_norise", 32'(rise_cnt), 32'(r0));
    check("brk_noerr",  32'(fe_cnt), 32'(f0 + 1));
    send(8'h55, 1'b1, BIT_CLKS);
    rx_p = 1'b1;
    repeat (20) @(negedge clk210_p);
    check("55_data",  32'(bus.rx_data_p), 32'h55);
    check("55_valid", 32'(bus.rx_valid_p), 32'd1);
    do_ack("55_ack");

    // Overrun: back-to-back, never acked
    o0 = ov_cnt;
    send(8'h11, 1'b1, BIT_CLKS);
    send(8'h22, 1'b1, BIT_CLKS);
    rx_p = 1'b1;
    repeat (20) @(negedge clk210_p);
    check("ovr_pulse", 32'(ov_cnt), 32'(o0 + 1));
    check("ovr_data",  32'(bus.rx_data_p), 32'h22);
    check("ovr_valid", 32'(bus.rx_valid_p), 32'd1);
    do_ack("ovr_ack");

    // Ack in the exact delivery cycle of the second byte
    o0 = ov_cnt;
    send(8'h11, 1'b1, BIT_CLKS);
    collide = 1'b1;
    send(8'h22, 1'b1, BIT_CLKS);
    collide = 1'b0;
    rx_p = 1'b1;
    repeat (20) @(negedge clk210_p);
    check("col_fired", 32'(ack_fires), 32'd1);
    check("col_noovr", 32'(ov_cnt), 32'(o0));
    check("col_valid", 32'(bus.rx_valid_p), 32'd1);
    check("col_data",  32'(bus.rx_data_p), 32'h22);
    do_ack("col_ack");

    // Loopback with +3% / -3% transmitter bit period
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 3; b++) begin
        send(lb[b], 1'b1, skew[s]);
        rx_p = 1'b1;
        repeat (200) @(negedge clk210_p);
        check($sformatf("lb%0d_data%0d", s, b), 32'(bus.rx_data_p), 32'(lb[b]));
        check($sformatf("lb%0d_valid%0d", s, b), 32'(bus.rx_valid_p), 32'd1);
        do_ack($sformatf("lb%0d_ack%0d", s, b));
      end
    end
    check("lb_noerr", 32'(fe_cnt), 32'd1);

    // Leave a byte pending, then reset mid-bit-4 of an all-zero frame
    send(8'hC3, 1'b1, BIT_CLKS);
    rx_p = 1'b1;
    repeat (200) @(negedge clk210_p);
    check("c3_data", 32'(bus.rx_data_p), 32'hC3);
    r0 = rise_cnt;
    f0 = fe_cnt;
    o0 = ov_cnt;
    frame_id++;
    rx_p = 1'b0;
    repeat (BIT_CLKS) @(negedge clk210_p);
    for (int i = 0; i < 8; i++) begin
      rx_p = 1'b0;
      if (i == 4) begin
        repeat (64) @(negedge clk210_p);
        reset_n_p = 1'b0;
        repeat (3) @(negedge clk210_p);
        check("mrst_data",  32'(bus.rx_data_p), 32'h00);
        check("mrst_valid", 32'(bus.rx_valid_p), 32'd0);
        reset_n_p = 1'b1;
        repeat (61) @(negedge clk210_p);
      end else begin
        repeat (BIT_CLKS) @(negedge clk210_p);
      end
    end
    rx_p = 1'b1;
    repeat (BIT_CLKS + 1400) @(negedge clk210_p);
    check("abort_norise", 32'(rise_cnt), 32'(r0));
    check("abort_valid",  32'(bus.rx_valid_p), 32'd0);
    check("abort_nopul",  32'(fe_cnt + ov_cnt), 32'(f0 + o0));
    send(8'h5A, 1'b1, BIT_CLKS);
    rx_p = 1'b1;
    repeat (20) @(negedge clk210_p);
    check("post_data",  32'(bus.rx_data_p), 32'h5A);
    check("post_valid", 32'(bus.rx_valid_p), 32'd1);
    do_ack("post_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
